// File: rtl/hiscore_pkg.sv
// Shared state encodings and constants for the high-score table and its flash request handshake.
package hiscore_pkg;

    localparam logic [15:0] ERASED_WORD = 16'hFFFF;
    localparam int          TMO_W       = 8;

    typedef enum logic [3:0] {
        ST_BOOT_WAIT  = 4'd0,
        ST_LOAD_REQ   = 4'd1,
        ST_LOAD_WAIT  = 4'd2,
        ST_SORT       = 4'd3,
        ST_IDLE       = 4'd4,
        ST_ERASE_REQ  = 4'd5,
        ST_ERASE_WAIT = 4'd6,
        ST_STORE_REQ  = 4'd7,
        ST_STORE_WAIT = 4'd8
    } hs_state_t;

    typedef enum logic [1:0] {
        REQ_IDLE = 2'd0,
        REQ_RISE = 2'd1,
        REQ_FALL = 2'd2
    } req_phase_t;

endpackage

// File: rtl/flash_req.sv
// One flash transaction: optional one-cycle request pulse, wait for busy to rise (bounded), then fall.
module flash_req
    import hiscore_pkg::*;
#(
    parameter int RISE_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_b,
    input  logic i_start,
    input  logic i_pulse,
    input  logic i_busy,
    output logic o_pulse,
    output logic o_done,
    output logic o_timeout
);

    localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(RISE_TIMEOUT - 1);

    req_phase_t       r_phase;
    req_phase_t       w_next_phase;
    logic [TMO_W-1:0] r_cnt;
    logic [TMO_W-1:0] w_next_cnt;
    logic             r_pulse;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_phase <= REQ_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_phase <= w_next_phase;
            r_cnt   <= w_next_cnt;
            r_pulse <= i_start & i_pulse & (r_phase == REQ_IDLE);
        end
    end

    // Handshake: the request pulse and the start of the rise wait coincide; done fires
    // in the cycle busy is seen low again, or when the rise wait runs out.
    always_comb begin
        w_next_phase = r_phase;
        w_next_cnt   = r_cnt;
        o_done       = 1'b0;
        o_timeout    = 1'b0;
        case (r_phase)
            REQ_IDLE: begin
                if (i_start) begin
                    w_next_phase = REQ_RISE;
                    w_next_cnt   = '0;
                end
            end
            REQ_RISE: begin
                if (i_busy) begin
                    w_next_phase = REQ_FALL;
                end else if (r_cnt == CNT_LAST) begin
                    o_done       = 1'b1;
                    o_timeout    = 1'b1;
                    w_next_phase = REQ_IDLE;
                end else begin
                    w_next_cnt = r_cnt + TMO_W'(1);
                end
            end
            REQ_FALL: begin
                if (!i_busy) begin
                    o_done       = 1'b1;
                    w_next_phase = REQ_IDLE;
                end
            end
            default: w_next_phase = REQ_IDLE;
        endcase
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/hiscore_table.sv
// Sorted top-N score table persisted in flash: loads at boot, rewrites all words after each change.
module hiscore_table
    import hiscore_pkg::*;
#(
    parameter int          ENTRIES      = 4,
    parameter int          SCORE_W      = 16,
    parameter logic [22:0] BASE_ADDR    = 23'd0,
    parameter int          RISE_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               score_valid,
    input  logic               clear_table,
    input  logic [2:0]         entry_idx,
    output logic [SCORE_W-1:0] entry_score,
    output logic [SCORE_W-1:0] top_score,
    output logic               writemode,
    output logic               dowrite,
    output logic [SCORE_W-1:0] wdata,
    output logic               doread,
    output logic [22:0]        raddr,
    input  logic               busy,
    input  logic [SCORE_W-1:0] frdata,
    output logic               table_busy,
    output logic               err,
    output logic [3:0]         state_out
);

    localparam int             IDX_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

    hs_state_t          r_state;
    hs_state_t          w_next_state;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_next_idx;
    logic [SCORE_W-1:0] r_table    [ENTRIES];
    logic [SCORE_W-1:0] w_sorted   [ENTRIES];
    logic [SCORE_W-1:0] w_inserted [ENTRIES];
    logic               w_changed;
    logic [SCORE_W-1:0] w_prev;
    logic [SCORE_W-1:0] w_entry;
    logic [SCORE_W-1:0] w_load_word;

    logic               r_writemode;
    logic [SCORE_W-1:0] r_wdata;
    logic [22:0]        r_raddr;
    logic               r_err;

    logic               r_pend_score;
    logic               r_pend_clear;
    logic [SCORE_W-1:0] r_pend_val;
    logic [SCORE_W-1:0] w_pend_held;
    logic [SCORE_W-1:0] w_pend_max;
    logic               w_take_score;
    logic               w_take_clear;

    logic               w_start;
    logic               w_start_pulse;
    logic               w_pulse;
    logic               w_done;
    logic               w_timeout;

    flash_req #(
        .RISE_TIMEOUT (RISE_TIMEOUT)
    ) u_req (
        .clk       (clk),
        .reset_b   (reset_b),
        .i_start   (w_start),
        .i_pulse   (w_start_pulse),
        .i_busy    (busy),
        .o_pulse   (w_pulse),
        .o_done    (w_done),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= ST_BOOT_WAIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_idx    = r_idx;
        w_start       = 1'b0;
        w_start_pulse = 1'b0;
        case (r_state)
            ST_BOOT_WAIT: begin
                if (!busy) begin
                    w_next_state = ST_LOAD_REQ;
                    w_next_idx   = '0;
                end
            end
            ST_LOAD_REQ: begin
                w_start       = 1'b1;
                w_start_pulse = 1'b1;
                w_next_state  = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: begin
                if (w_done) begin
                    if (r_idx == IDX_LAST) begin
                        w_next_state = ST_SORT;
                        w_next_idx   = '0;
                    end else begin
                        w_next_state = ST_LOAD_REQ;
                        w_next_idx   = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_SORT: begin
                if (r_idx == IDX_LAST) begin
                    w_next_state = ST_IDLE;
                    w_next_idx   = '0;
                end else begin
                    w_next_idx = r_idx + IDX_W'(1);
                end
            end
            ST_IDLE: begin
                if (r_pend_clear || (r_pend_score && w_changed)) begin
                    w_next_state = ST_ERASE_REQ;
                end
            end
            ST_ERASE_REQ: begin
                w_start      = 1'b1;
                w_next_state = ST_ERASE_WAIT;
            end
            ST_ERASE_WAIT: begin
                if (w_done) begin
                    w_next_state = ST_STORE_REQ;
                    w_next_idx   = '0;
                end
            end
            ST_STORE_REQ: begin
                w_start       = 1'b1;
                w_start_pulse = 1'b1;
                w_next_state  = ST_STORE_WAIT;
            end
            ST_STORE_WAIT: begin
                if (w_done) begin
                    if (r_idx == IDX_LAST) begin
                        w_next_state = ST_IDLE;
                        w_next_idx   = '0;
                    end else begin
                        w_next_state = ST_STORE_REQ;
                        w_next_idx   = r_idx + IDX_W'(1);
                    end
                end
            end
            default: w_next_state = ST_BOOT_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_idx       <= '0;
            r_writemode <= 1'b0;
            r_wdata     <= '0;
            r_raddr     <= BASE_ADDR;
            r_err       <= 1'b0;
        end else begin
            r_idx <= w_next_idx;
            if (w_timeout) r_err <= 1'b1;
            if (r_state == ST_LOAD_REQ) r_raddr <= BASE_ADDR + 23'(r_idx);
            if (r_state == ST_STORE_REQ) r_wdata <= r_table[r_idx];
            if (r_state == ST_ERASE_REQ) begin
                r_writemode <= 1'b1;
            end else if (r_state == ST_STORE_WAIT && w_done && r_idx == IDX_LAST) begin
                r_writemode <= 1'b0;
            end
        end
    end

    // A read that never got a busy response carries no data, so it loads as empty.
    assign w_load_word = (w_timeout || frdata == SCORE_W'(ERASED_WORD)) ? '0 : frdata;

    // One odd/even transposition pass per SORT cycle, pass parity taken from the pass counter.
    always_comb begin
        w_sorted = r_table;
        for (int j = 0; j < ENTRIES - 1; j++) begin
            if (((j % 2) == 1) == r_idx[0] && r_table[j] < r_table[j+1]) begin
                w_sorted[j]   = r_table[j+1];
                w_sorted[j+1] = r_table[j];
            end
        end
    end

    // Strict greater-than places a new score below any existing equal score.
    always_comb begin
        w_changed = 1'b0;
        w_prev    = '0;
        for (int j = 0; j < ENTRIES; j++) begin
            if (w_changed) begin
                w_inserted[j] = w_prev;
            end else if (r_pend_val > r_table[j]) begin
                w_inserted[j] = r_pend_val;
                w_changed     = 1'b1;
            end else begin
                w_inserted[j] = r_table[j];
            end
            w_prev = r_table[j];
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int j = 0; j < ENTRIES; j++) r_table[j] <= '0;
        end else begin
            case (r_state)
                ST_LOAD_WAIT: if (w_done) r_table[r_idx] <= w_load_word;
                ST_SORT:      r_table <= w_sorted;
                ST_IDLE: begin
                    if (r_pend_clear) begin
                        for (int j = 0; j < ENTRIES; j++) r_table[j] <= '0;
                    end else if (r_pend_score && w_changed) begin
                        r_table <= w_inserted;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_take_clear = (r_state == ST_IDLE) && r_pend_clear;
    assign w_take_score = (r_state == ST_IDLE) && r_pend_score && !r_pend_clear;
    assign w_pend_held  = w_take_score ? '0 : r_pend_val;
    assign w_pend_max   = (score_in > w_pend_held) ? score_in : w_pend_held;

    // Requests accumulate while busy: scores keep only the best, a clear discards them.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_pend_score <= 1'b0;
            r_pend_clear <= 1'b0;
            r_pend_val   <= '0;
        end else if (clear_table) begin
            r_pend_clear <= 1'b1;
            r_pend_score <= 1'b0;
            r_pend_val   <= '0;
        end else begin
            if (w_take_clear) r_pend_clear <= 1'b0;
            if (score_valid) begin
                r_pend_score <= 1'b1;
                r_pend_val   <= w_pend_max;
            end else if (w_take_score) begin
                r_pend_score <= 1'b0;
                r_pend_val   <= '0;
            end
        end
    end

    always_comb begin
        w_entry = '0;
        for (int j = 0; j < ENTRIES; j++) begin
            if (entry_idx == 3'(j)) w_entry = r_table[j];
        end
    end

    assign entry_score = w_entry;
    assign top_score   = r_table[0];
    assign writemode   = r_writemode;
    assign wdata       = r_wdata;
    assign raddr       = r_raddr;
    assign doread      = w_pulse && (r_state == ST_LOAD_WAIT);
    assign dowrite     = w_pulse && (r_state == ST_STORE_WAIT);
    assign table_busy  = (r_state != ST_IDLE);
    assign err         = r_err;
    assign state_out   = r_state;

endmodule

// File: doc/hiscore_table.md
# hiscore_table

Persistent top-N high-score table sitting upstream of `flash_manager`, alongside `max_score`. At boot it reads N score words from flash into a sorted register table. On each game-over score or clear request it updates the table and rewrites all N words through the `flash_manager` erase/write handshake. It exposes the table to display logic via an indexed read port.

## Interface
- `ENTRIES`, 4: table depth N, 2..8
- `SCORE_W`, 16: score width; must equal flash word width
- `BASE_ADDR`, 23'd0: flash word address of entry 0; entry i is at `BASE_ADDR+i`
- `RISE_TIMEOUT`, 255: maximum cycles to wait for `busy` to rise after a request

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock
- `reset_b`  in  1  async active-low reset
- `score_in`  in  SCORE_W  final game score
- `score_valid`  in  1  one-cycle pulse, `score_in` valid
- `clear_table`  in  1  one-cycle pulse, zero all entries
- `entry_idx`  in  3  display read index
- `entry_score`  out  SCORE_W  `table[entry_idx]`, combinational; 0 if idx ≥ ENTRIES
- `top_score`  out  SCORE_W  `table[0]`
- `writemode`  out  1  to `flash_manager`
- `dowrite`  out  1  to `flash_manager`
- `wdata`  out  SCORE_W  to `flash_manager`
- `doread`  out  1  to `flash_manager`
- `raddr`  out  23  to `flash_manager`
- `busy`  in  1  from `flash_manager`
- `frdata`  in  SCORE_W  from `flash_manager`
- `table_busy`  out  1  high in every state except IDLE
- `err`  out  1  sticky; set on handshake timeout, cleared only by reset
- `state_out`  out  4  state encoding, for debug

## Operation
- Reset values:
  - all table entries 0, `writemode=0`, `dowrite=0`, `doread=0`, `raddr=BASE_ADDR`, `wdata=0`, `err=0`
  - pending flags clear; state BOOT_WAIT
- Request primitive, used by every transaction: pulse `doread` or `dowrite` for one cycle, then wait for `busy`=1, then wait for `busy`=0.
  - If `busy` has not risen within RISE_TIMEOUT cycles: set `err` and treat the transaction as complete.
- States:
  - BOOT_WAIT: wait for `busy`=0 → LOAD_REQ with i=0.
  - LOAD_REQ: `raddr=BASE_ADDR+i`, pulse `doread` → LOAD_WAIT.
  - LOAD_WAIT: on completion, `table[i] <= (frdata==16'hFFFF) ? 0 : frdata`. Next LOAD_REQ with i+1, or SORT after i=ENTRIES-1.
  - SORT: ENTRIES passes of odd/even compare-swap, descending, one pass per cycle → IDLE. This guards against corrupt flash order.
  - IDLE: pending clear has priority.
    - Clear: zero the table → ERASE_REQ.
    - Pending score: insert → ERASE_REQ if the table changed, else stay in IDLE.
  - ERASE_REQ: `writemode<=1` → ERASE_WAIT.
  - ERASE_WAIT: wait for `busy` rise then fall (the erase) → STORE_REQ with i=0.
  - STORE_REQ: `wdata=table[i]`, pulse `dowrite` → STORE_WAIT.
  - STORE_WAIT: on completion, i+1 → STORE_REQ; after the last entry, `writemode<=0` → IDLE.
- Insertion:
  - Position p = first index with `score_in > table[p]`, so a new score ties below existing equal scores.
  - Entries p..N-2 shift down and the last entry is dropped. If no p exists, the table is unchanged.
- Pending capture:
  - `score_valid` in any state sets `pend_score` flag; value = max(held, `score_in`).
  - `clear_table` in any state sets `pend_clear`. A clear also discards `pend_score`.
  - Both flags are consumed only in IDLE.

## Timing
- Boot load latency ≈ ENTRIES × (flash read) + ENTRIES + 2 cycles.
- IDLE → ERASE_REQ takes 1 cycle after a pending event: the insert is registered that cycle.
- `top_score` and `entry_score` reflect the new table one cycle after IDLE consumes the event, before the flash rewrite finishes.
- `dowrite` and `doread` are never high for more than one cycle, and never while `busy`=1.
- Simultaneous `score_valid` and `clear_table` in the same cycle: the clear wins and the score is discarded.
- Reset mid-write: all state is lost. The next boot reloads whatever flash holds. Erased words read back as 0.

## Structure
- `hiscore_pkg`: state enum (4-bit), `ERASED_WORD=16'hFFFF`, timeout width constant.
- Sub-module `flash_req`: the single-request handshake (pulse, rise wait with timeout, fall wait, `done`, `timeout` outputs), instantiated once.

## Test plan
- Boot with flash model holding {500,300,0xFFFF,900} → table {900,500,300,0}; `err`=0; 4 `doread` pulses at addrs 0..3.
- From table {900,500,300,0}, `score_valid` with 400 → table {900,500,400,300}. Erase seen, then `wdata` 900,500,400,300 in order on 4 `dowrite` pulses.
- From table {900,500,400,300}, score 300 (tie with last) → no change, no `writemode` assertion.
- `clear_table` during STORE_WAIT → finish current rewrite, then table all 0 and a second full erase+write of zeros.
- Flash model never raises `busy` after `doread` → `err`=1 after 255 cycles, boot proceeds to IDLE.
- Assert `reset_b` low during STORE_REQ → all outputs at reset values asynchronously, reboot reloads flash contents.
